lemmings_array: RTL and testbench

- Parametrised successor to the single-lemming walker FSM: NUM_LEM independent lemming controllers in one block, sharing clk/reset.
- Adds a configurable splat threshold, an explicit per-lemming splat flag and an aggregate alive count and all-dead flag.
- Sits between the level/terrain model (bump, ground and dig stimuli per lemming) and the scoreboard/display logic.

---
 rtl/lemmings_array_pkg.sv | 34 +++
 rtl/lemmings_array_fsm.sv | 146 ++++++++++++++
 rtl/lemmings_array.sv | 68 ++++++
 tb/tb_lemmings_array.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lemmings_array_pkg.sv
// lemmings_array_pkg: state encodings and small helpers shared by the
// lemming channel FSM and the lemmings_array top.
// Optional feature macro: LEMMINGS_BLOCKER_EN (undefined by default) adds
// the BLOCK state.
package lemmings_array_pkg;

  // Binary 3-bit state encoding, one value per behaviour of a channel.
  typedef enum logic [2:0] {
    ST_WALK_L = 3'd0,
    ST_WALK_R = 3'd1,
    ST_FALL_L = 3'd2,
    ST_FALL_R = 3'd3,
    ST_DIG_L  = 3'd4,
    ST_DIG_R  = 3'd5,
    ST_SPLAT  = 3'd6
`ifdef LEMMINGS_BLOCKER_EN
    ,
    ST_BLOCK  = 3'd7
`endif
  } lem_state_t;

  localparam int STATE_W = 3;

  // Width of the fall counter: just enough to hold 0..splat_cycles.
  function automatic int fall_cnt_width(input int splat_cycles);
    return (splat_cycles < 1) ? 1 : $clog2(splat_cycles + 1);
  endfunction

  // True for either falling state.
  function automatic logic is_fall(input lem_state_t s);
    return (s == ST_FALL_L) || (s == ST_FALL_R);
  endfunction

endpackage

// File: rtl/lemmings_array_fsm.sv
// lemming_fsm: one lemming channel. Holds the state register, the fall
// counter and registered one-hot behaviour outputs (Moore: outputs are
// loaded from the next state, so nothing combinational reaches a port).
// Optional feature macro: LEMMINGS_BLOCKER_EN adds block/blocking and the
// BLOCK state.
module lemming_fsm
  import lemmings_array_pkg::*;
#(
  parameter int SPLAT_CYCLES = 20
) (
  input  logic               clk,
  input  logic               areset_n,
  input  logic               bump_left,
  input  logic               bump_right,
  input  logic               ground,
  input  logic               dig,
`ifdef LEMMINGS_BLOCKER_EN
  input  logic               block,
  output logic               blocking,
`endif
  output logic               walk_left,
  output logic               walk_right,
  output logic               aaah,
  output logic               digging,
  output logic               splat,
  output logic [STATE_W-1:0] dbg_state
);

  localparam int CW = fall_cnt_width(SPLAT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(SPLAT_CYCLES);

  lem_state_t    r_state;
  lem_state_t    w_next_state;
  logic [CW-1:0] r_fall_cnt;
  logic          r_walk_left;
  logic          r_walk_right;
  logic          r_aaah;
  logic          r_digging;
  logic          r_splat;
`ifdef LEMMINGS_BLOCKER_EN
  logic          r_blocking;
`endif

  // Next-state rules: loss of ground wins, then dig, then block, then bumps.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_WALK_L: begin
        if (!ground) begin
          w_next_state = ST_FALL_L;
        end else if (dig) begin
          w_next_state = ST_DIG_L;
`ifdef LEMMINGS_BLOCKER_EN
        end else if (block) begin
          w_next_state = ST_BLOCK;
`endif
        end else if (bump_left) begin
          w_next_state = ST_WALK_R;
        end
      end
      ST_WALK_R: begin
        if (!ground) begin
          w_next_state = ST_FALL_R;
        end else if (dig) begin
          w_next_state = ST_DIG_R;
`ifdef LEMMINGS_BLOCKER_EN
        end else if (block) begin
          w_next_state = ST_BLOCK;
`endif
        end else if (bump_right) begin
          w_next_state = ST_WALK_L;
        end
      end
      ST_DIG_L: begin
        if (!ground) w_next_state = ST_FALL_L;
      end
      ST_DIG_R: begin
        if (!ground) w_next_state = ST_FALL_R;
      end
      // Landing after more than SPLAT_CYCLES cycles of falling is fatal.
      ST_FALL_L: begin
        if (ground) w_next_state = (r_fall_cnt >= CNT_MAX) ? ST_SPLAT : ST_WALK_L;
      end
      ST_FALL_R: begin
        if (ground) w_next_state = (r_fall_cnt >= CNT_MAX) ? ST_SPLAT : ST_WALK_R;
      end
      ST_SPLAT: begin
        w_next_state = ST_SPLAT;
      end
`ifdef LEMMINGS_BLOCKER_EN
      // A blocker that loses its ground always falls to the left.
      ST_BLOCK: begin
        if (!ground) w_next_state = ST_FALL_L;
      end
`endif
      default: begin
        w_next_state = ST_WALK_L;
      end
    endcase
  end

  // State, fall counter and registered outputs; async reset to WALK_L.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state      <= ST_WALK_L;
      r_fall_cnt   <= '0;
      r_walk_left  <= 1'b1;
      r_walk_right <= 1'b0;
      r_aaah       <= 1'b0;
      r_digging    <= 1'b0;
      r_splat      <= 1'b0;
`ifdef LEMMINGS_BLOCKER_EN
      r_blocking   <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      // Counter restarts on entry to a fall and saturates so it never wraps.
      if (is_fall(w_next_state)) begin
        if (!is_fall(r_state)) begin
          r_fall_cnt <= '0;
        end else if (r_fall_cnt < CNT_MAX) begin
          r_fall_cnt <= r_fall_cnt + CW'(1);
        end
      end
      r_walk_left  <= (w_next_state == ST_WALK_L);
      r_walk_right <= (w_next_state == ST_WALK_R);
      r_aaah       <= is_fall(w_next_state);
      r_digging    <= (w_next_state == ST_DIG_L) || (w_next_state == ST_DIG_R);
      r_splat      <= (w_next_state == ST_SPLAT);
`ifdef LEMMINGS_BLOCKER_EN
      r_blocking   <= (w_next_state == ST_BLOCK);
`endif
    end
  end

  assign walk_left  = r_walk_left;
  assign walk_right = r_walk_right;
  assign aaah       = r_aaah;
  assign digging    = r_digging;
  assign splat      = r_splat;
  assign dbg_state  = r_state;
`ifdef LEMMINGS_BLOCKER_EN
  assign blocking   = r_blocking;
`endif

endmodule

// File: rtl/lemmings_array.sv
// lemmings_array: NUM_LEM independent lemming channels sharing clk and an
// asynchronous active-low reset, plus an alive count and all-dead flag.
// dbg_state exposes every channel's 3-bit state, channel i in bits [3i+:3].
// Optional feature macro: LEMMINGS_BLOCKER_EN adds block/blocking ports.
module lemmings_array
  import lemmings_array_pkg::*;
#(
  parameter int NUM_LEM      = 4,
  parameter int SPLAT_CYCLES = 20,
  localparam int AW          = $clog2(NUM_LEM + 1)
) (
  input  logic                         clk,
  input  logic                         areset_n,
  input  logic [NUM_LEM-1:0]           bump_left,
  input  logic [NUM_LEM-1:0]           bump_right,
  input  logic [NUM_LEM-1:0]           ground,
  input  logic [NUM_LEM-1:0]           dig,
`ifdef LEMMINGS_BLOCKER_EN
  input  logic [NUM_LEM-1:0]           block,
  output logic [NUM_LEM-1:0]           blocking,
`endif
  output logic [NUM_LEM-1:0]           walk_left,
  output logic [NUM_LEM-1:0]           walk_right,
  output logic [NUM_LEM-1:0]           aaah,
  output logic [NUM_LEM-1:0]           digging,
  output logic [NUM_LEM-1:0]           splat,
  output logic [AW-1:0]                alive_cnt,
  output logic                         all_dead,
  output logic [STATE_W*NUM_LEM-1:0]   dbg_state
);

  logic [AW-1:0] w_alive_cnt;

  for (genvar g = 0; g < NUM_LEM; g++) begin : g_lem
    lemming_fsm #(
      .SPLAT_CYCLES(SPLAT_CYCLES)
    ) u_fsm (
      .clk        (clk),
      .areset_n   (areset_n),
      .bump_left  (bump_left[g]),
      .bump_right (bump_right[g]),
      .ground     (ground[g]),
      .dig        (dig[g]),
`ifdef LEMMINGS_BLOCKER_EN
      .block      (block[g]),
      .blocking   (blocking[g]),
`endif
      .walk_left  (walk_left[g]),
      .walk_right (walk_right[g]),
      .aaah       (aaah[g]),
      .digging    (digging[g]),
      .splat      (splat[g]),
      .dbg_state  (dbg_state[STATE_W*g +: STATE_W])
    );
  end

  // Popcount of channels not splatted, taken from the registered splat flags.
  always_comb begin
    w_alive_cnt = '0;
    for (int i = 0; i < NUM_LEM; i++) begin
      if (!splat[i]) w_alive_cnt = w_alive_cnt + AW'(1);
    end
  end

  assign alive_cnt = w_alive_cnt;
  assign all_dead  = (w_alive_cnt == '0);

endmodule

// File: tb/tb_lemmings_array.sv
// tb_lemmings_array: two instances (4 channels / 20-cycle limit and
// 2 channels / 3-cycle limit) checked every cycle against a behavioural
// model, plus directed literal checks on key points.
// Optional feature macro: LEMMINGS_BLOCKER_EN enables the blocker section.
module tb_lemmings_array;

`ifdef LEMMINGS_BLOCKER_EN
  localparam bit BLK_EN = 1'b1;
`else
  localparam bit BLK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic areset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: 4 channels, limit 20 ----------------
  logic [3:0] bl_a = '0, br_a = '0, gnd_a = 4'hF, dig_a = '0, blk_a = '0;
  logic [3:0] walk_left_a, walk_right_a, aaah_a, digging_a, splat_a, blocking_a;
  logic [2:0] alive_cnt_a;
  logic       all_dead_a;
  logic [11:0] dbg_a;

  lemmings_array #(.NUM_LEM(4), .SPLAT_CYCLES(20)) u_dut_a (
    .clk(clk), .areset_n(areset_n),
    .bump_left(bl_a), .bump_right(br_a), .ground(gnd_a), .dig(dig_a),
`ifdef LEMMINGS_BLOCKER_EN
    .block(blk_a), .blocking(blocking_a),
`endif
    .walk_left(walk_left_a), .walk_right(walk_right_a), .aaah(aaah_a),
    .digging(digging_a), .splat(splat_a), .alive_cnt(alive_cnt_a),
    .all_dead(all_dead_a), .dbg_state(dbg_a)
  );

  // ---------------- DUT B: 2 channels, limit 3 ----------------
  logic [1:0] bl_b = '0, br_b = '0, gnd_b = 2'b11, dig_b = '0, blk_b = '0;
  logic [1:0] walk_left_b, walk_right_b, aaah_b, digging_b, splat_b, blocking_b;
  logic [1:0] alive_cnt_b;
  logic       all_dead_b;
  logic [5:0] dbg_b;

  lemmings_array #(.NUM_LEM(2), .SPLAT_CYCLES(3)) u_dut_b (
    .clk(clk), .areset_n(areset_n),
    .bump_left(bl_b), .bump_right(br_b), .ground(gnd_b), .dig(dig_b),
`ifdef LEMMINGS_BLOCKER_EN
    .block(blk_b), .blocking(blocking_b),
`endif
    .walk_left(walk_left_b), .walk_right(walk_right_b), .aaah(aaah_b),
    .digging(digging_b), .splat(splat_b), .alive_cnt(alive_cnt_b),
    .all_dead(all_dead_b), .dbg_state(dbg_b)
  );

`ifndef LEMMINGS_BLOCKER_EN
  assign blocking_a = '0;
  assign blocking_b = '0;
`endif

  // ---------------- behavioural model ----------------
  typedef enum int {M_WALK, M_FALL, M_DIG, M_BLOCK, M_SPLAT} mmode_t;
  typedef struct {
    mmode_t mode;
    bit     right;
    int     flen;   // cycles spent falling so far, unbounded
  } lem_t;

  lem_t ma[4];
  lem_t mb[2];

  function automatic lem_t lem_step(lem_t s, bit bl, bit br, bit g, bit d, bit b, int sc);
    lem_t n = s;
    case (s.mode)
      M_WALK: begin
        if (!g) begin n.mode = M_FALL; n.flen = 1; end
        else if (d) n.mode = M_DIG;
        else if (b && BLK_EN) n.mode = M_BLOCK;
        else if (s.right ? br : bl) n.right = !s.right;
      end
      M_DIG:   if (!g) begin n.mode = M_FALL; n.flen = 1; end
      M_BLOCK: if (!g) begin n.mode = M_FALL; n.right = 1'b0; n.flen = 1; end
      M_FALL: begin
        if (g) n.mode = (s.flen > sc) ? M_SPLAT : M_WALK;
        else   n.flen = s.flen + 1;
      end
      default: ;
    endcase
    return n;
  endfunction

  function automatic logic [27:0] pack_a();
    logic [3:0] wl, wr, fa, dg, sp, bk;
    int alive;
    alive = 0;
    for (int i = 0; i < 4; i++) begin
      wl[i] = (ma[i].mode == M_WALK) && !ma[i].right;
      wr[i] = (ma[i].mode == M_WALK) &&  ma[i].right;
      fa[i] = (ma[i].mode == M_FALL);
      dg[i] = (ma[i].mode == M_DIG);
      sp[i] = (ma[i].mode == M_SPLAT);
      bk[i] = (ma[i].mode == M_BLOCK);
      if (ma[i].mode != M_SPLAT) alive++;
    end
    return {bk, sp, dg, fa, wr, wl, 3'(alive), alive == 0};
  endfunction

  function automatic logic [14:0] pack_b();
    logic [1:0] wl, wr, fa, dg, sp, bk;
    int alive;
    alive = 0;
    for (int i = 0; i < 2; i++) begin
      wl[i] = (mb[i].mode == M_WALK) && !mb[i].right;
      wr[i] = (mb[i].mode == M_WALK) &&  mb[i].right;
      fa[i] = (mb[i].mode == M_FALL);
      dg[i] = (mb[i].mode == M_DIG);
      sp[i] = (mb[i].mode == M_SPLAT);
      bk[i] = (mb[i].mode == M_BLOCK);
      if (mb[i].mode != M_SPLAT) alive++;
    end
    return {bk, sp, dg, fa, wr, wl, 2'(alive), alive == 0};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) ma[i] = '{M_WALK, 1'b0, 0};
    for (int i = 0; i < 2; i++) mb[i] = '{M_WALK, 1'b0, 0};
  endfunction

  // ---------------- scoreboard ----------------
  logic [27:0] exp_qa[$];
  logic [14:0] exp_qb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on the same edges as the DUT and queues its expectation.
  always @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      model_reset();
      exp_qa.delete();
      exp_qb.delete();
    end else begin
      for (int i = 0; i < 4; i++)
        ma[i] = lem_step(ma[i], bl_a[i], br_a[i], gnd_a[i], dig_a[i], blk_a[i], 20);
      for (int i = 0; i < 2; i++)
        mb[i] = lem_step(mb[i], bl_b[i], br_b[i], gnd_b[i], dig_b[i], blk_b[i], 3);
      exp_qa.push_back(pack_a());
      exp_qb.push_back(pack_b());
    end
  end

  // Every falling edge: whole output word of both DUTs against the model.
  always @(negedge clk) begin : cmp
    logic [27:0] ea;
    logic [14:0] eb;
    logic [27:0] act_a;
    logic [14:0] act_b;
    act_a = {blocking_a, splat_a, digging_a, aaah_a, walk_right_a, walk_left_a,
             alive_cnt_a, all_dead_a};
    act_b = {blocking_b, splat_b, digging_b, aaah_b, walk_right_b, walk_left_b,
             alive_cnt_b, all_dead_b};
    if (!areset_n) begin
      chk("cmp_a_reset", 32'(act_a), 32'(pack_a()));
      chk("cmp_b_reset", 32'(act_b), 32'(pack_b()));
    end else if (exp_qa.size() == 0 || exp_qb.size() == 0) begin
      chk("cmp_queue_empty", 32'(exp_qa.size() + exp_qb.size()), 32'd2);
    end else begin
      ea = exp_qa.pop_front();
      eb = exp_qb.pop_front();
      chk("cmp_a", 32'(act_a), 32'(ea));
      chk("cmp_b", 32'(act_b), 32'(eb));
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the falling edge, clear of both edges.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    model_reset();
    cyc(2);
    chk("rst_walk_left_a", 32'(walk_left_a), 32'hF);
    chk("rst_alive_a", 32'(alive_cnt_a), 32'd4);
    chk("rst_all_dead_a", 32'(all_dead_a), 32'd0);
    chk("rst_walk_left_b", 32'(walk_left_b), 32'h3);
    areset_n = 1'b1;

    // Walk and bumps on channel 0.
    cyc(1);
    bl_a = 4'b0001;
    cyc(1);
    bl_a = 4'b0000;
    chk("t1_turn_right", 32'(walk_right_a[0]), 32'd1);
    bl_a = 4'b0001; br_a = 4'b0001;
    cyc(1);
    chk("t1_toggle_left", 32'(walk_left_a[0]), 32'd1);
    cyc(1);
    chk("t1_toggle_right", 32'(walk_right_a[0]), 32'd1);
    bl_a = '0; br_a = '0;
    chk("t1_others_left", 32'(walk_left_a[3:1]), 32'h7);

    // 20-cycle fall survives, 21-cycle fall splats.
    gnd_a = 4'b1110;
    cyc(1);
    chk("t2_aaah", 32'(aaah_a[0]), 32'd1);
    cyc(19);
    gnd_a = 4'hF;
    cyc(1);
    chk("t2_survive_20", 32'(walk_right_a[0]), 32'd1);
    gnd_a = 4'b1110;
    cyc(21);
    gnd_a = 4'hF;
    cyc(1);
    chk("t2_splat_21", 32'(splat_a[0]), 32'd1);
    chk("t2_alive_3", 32'(alive_cnt_a), 32'd3);
    for (int k = 0; k < 10; k++) begin
      bl_a[0]  = 1'($urandom_range(0, 1));
      br_a[0]  = 1'($urandom_range(0, 1));
      gnd_a[0] = 1'($urandom_range(0, 1));
      dig_a[0] = 1'($urandom_range(0, 1));
      cyc(1);
    end
    bl_a = '0; br_a = '0; gnd_a = 4'hF; dig_a = '0;
    chk("t2_splat_held", 32'(splat_a[0]), 32'd1);

    // Digging on channel 1, priority on channel 2.
    bl_a = 4'b0010;
    cyc(1);
    bl_a = '0;
    chk("t3_ch1_right", 32'(walk_right_a[1]), 32'd1);
    dig_a = 4'b0010; bl_a = 4'b0010; br_a = 4'b0010;
    cyc(1);
    chk("t3_digging", 32'(digging_a[1]), 32'd1);
    cyc(1);
    chk("t3_dig_ignores_bump", 32'(digging_a[1]), 32'd1);
    dig_a = '0; bl_a = '0; br_a = '0;
    gnd_a = 4'b1101;
    cyc(1);
    chk("t3_dig_fall", 32'(aaah_a[1]), 32'd1);
    cyc(2);
    gnd_a = 4'hF;
    cyc(1);
    chk("t3_land_right", 32'(walk_right_a[1]), 32'd1);
    gnd_a = 4'b1011; dig_a = 4'b0100; bl_a = 4'b0100;
    cyc(1);
    chk("t3_prio_aaah", 32'(aaah_a[2]), 32'd1);
    chk("t3_prio_not_dig", 32'(digging_a[2]), 32'd0);
    gnd_a = 4'hF; dig_a = '0; bl_a = '0;
    cyc(1);
    chk("t3_ch2_land", 32'(walk_left_a[2]), 32'd1);

    // Small threshold on instance B.
    gnd_b = 2'b10;
    cyc(3);
    gnd_b = 2'b11;
    cyc(1);
    chk("t4_survive_3", 32'(walk_left_b[0]), 32'd1);
    gnd_b = 2'b10;
    cyc(4);
    gnd_b = 2'b11;
    cyc(1);
    chk("t4_splat_4", 32'(splat_b[0]), 32'd1);
    chk("t4_alive_1", 32'(alive_cnt_b), 32'd1);

    // Long fall: counter must saturate, not wrap into the survivable range.
    gnd_b = 2'b01;
    cyc(200);
    gnd_b = 2'b11;
    cyc(1);
    chk("t5_splat_long", 32'(splat_b[1]), 32'd1);
    chk("t5_alive_0", 32'(alive_cnt_b), 32'd0);
    chk("t5_all_dead", 32'(all_dead_b), 32'd1);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2;
    areset_n = 1'b0;
    #1;
    chk("t4_async_walk_left_b", 32'(walk_left_b), 32'h3);
    chk("t4_async_splat_b", 32'(splat_b), 32'h0);
    chk("t4_async_walk_left_a", 32'(walk_left_a), 32'hF);
    cyc(2);
    areset_n = 1'b1;
    cyc(1);
    chk("t4_after_reset_alive_b", 32'(alive_cnt_b), 32'd2);

`ifdef LEMMINGS_BLOCKER_EN
    // Blocker on channel 3.
    blk_a = 4'b1000;
    cyc(1);
    chk("t6_blocking", 32'(blocking_a[3]), 32'd1);
    blk_a = '0; bl_a = 4'b1000; br_a = 4'b1000;
    cyc(2);
    chk("t6_block_held", 32'(blocking_a[3]), 32'd1);
    bl_a = '0; br_a = '0;
    gnd_a = 4'b0111;
    cyc(1);
    chk("t6_block_fall", 32'(aaah_a[3]), 32'd1);
    cyc(1);
    gnd_a = 4'hF;
    cyc(1);
    chk("t6_block_land_left", 32'(walk_left_a[3]), 32'd1);
`endif

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
